mac_stream: RTL and testbench

Parameterised multiply-accumulate engine with decoupled operand streams, the next generation of the team's fixed 4-bit `mac` block. Operands A and B arrive on independent valid/ready channels and are paired in order through per-channel buffers. Each product is accumulated over a group of ACC_LEN pairs, and the group sum is emitted with a one-cycle `out_valid` strobe. It sits between the operand sources and the result checker/consumer in the datapath.

---
 rtl/mac_pkg.sv | 34 +++
 rtl/mac_pair_fifo.sv | 77 +++++++
 rtl/mac_stream.sv | 130 +++++++++++++
 tb/tb_mac_stream.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// ============================================================================
// Module : mac_pkg
// Brief  : Shared helpers and types for the mac_stream multiply-accumulate slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mac_pkg;

    // Products are carried at this fixed width, sign- or zero-extended.
    // OUT_W must not exceed it.
    localparam int MAC_PROD_MAX_W = 64;

    function automatic int mac_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int mac_out_w(input int data_w, input int acc_len);
        return 2 * data_w + mac_clog2(acc_len);
    endfunction

    typedef struct packed {
        logic [MAC_PROD_MAX_W-1:0] prod;
        logic                      valid;
    } mac_stage_t;

endpackage

`default_nettype wire

// File: rtl/mac_pair_fifo.sv
// ============================================================================
// Module : mac_pair_fifo
// Brief  : Per-channel operand buffer with registered ready and no fall-through.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_pair_fifo
    import mac_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_valid,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             ready
);

    localparam int AW = mac_clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             push;
    logic             full;

    assign push  = push_valid & ready;
    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);
    assign head  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // A slot freed from full is advertised one edge later, so ready is
    // guaranteed low for every cycle the buffer is full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            ready <= !full && (count_next != FULL_COUNT);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mac_stream.sv
// ============================================================================
// Module : mac_stream
// Brief  : Paired-stream multiply-accumulate, one result per ACC_LEN pairs.
//          MAC_SIGNED_EN selects two's-complement operands (default unsigned).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_stream
    import mac_pkg::*;
#(
    parameter  int DATA_W    = 4,
    parameter  int ACC_LEN   = 8,
    parameter  int BUF_DEPTH = 4,
    localparam int OUT_W     = mac_out_w(DATA_W, ACC_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_a,
    input  logic              in_valid_a,
    output logic              in_ready_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_valid_b,
    output logic              in_ready_b,
    output logic [OUT_W-1:0]  mac_out,
    output logic              out_valid,
    output logic              overflow
);

    localparam int              CNT_W = mac_clog2(ACC_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

    logic [DATA_W-1:0]         head_a;
    logic [DATA_W-1:0]         head_b;
    logic                      empty_a;
    logic                      empty_b;
    logic                      pop;
    logic [2*DATA_W-1:0]       a_ext;
    logic [2*DATA_W-1:0]       b_ext;
    logic [2*DATA_W-1:0]       prod_raw;
    logic [MAC_PROD_MAX_W-1:0] prod_ext;
    mac_stage_t                stage;
    logic [OUT_W-1:0]          acc;
    logic [OUT_W-1:0]          acc_sum;
    logic [CNT_W-1:0]          cnt;

    mac_pair_fifo #(.WIDTH(DATA_W), .DEPTH(BUF_DEPTH)) u_fifo_a (
        .clk        (clk),
        .reset      (reset),
        .push_data  (in_a),
        .push_valid (in_valid_a),
        .pop        (pop),
        .head       (head_a),
        .empty      (empty_a),
        .ready      (in_ready_a)
    );

    mac_pair_fifo #(.WIDTH(DATA_W), .DEPTH(BUF_DEPTH)) u_fifo_b (
        .clk        (clk),
        .reset      (reset),
        .push_data  (in_b),
        .push_valid (in_valid_b),
        .pop        (pop),
        .head       (head_b),
        .empty      (empty_b),
        .ready      (in_ready_b)
    );

    assign pop = ~empty_a & ~empty_b;

    // The low 2*DATA_W bits of the product are identical for signed and
    // unsigned operands once extended; only the extension differs.
`ifdef MAC_SIGNED_EN
    assign a_ext    = {{DATA_W{head_a[DATA_W-1]}}, head_a};
    assign b_ext    = {{DATA_W{head_b[DATA_W-1]}}, head_b};
    assign prod_raw = a_ext * b_ext;
    assign prod_ext = MAC_PROD_MAX_W'($signed(prod_raw));
`else
    assign a_ext    = {{DATA_W{1'b0}}, head_a};
    assign b_ext    = {{DATA_W{1'b0}}, head_b};
    assign prod_raw = a_ext * b_ext;
    assign prod_ext = MAC_PROD_MAX_W'(prod_raw);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage <= '0;
        end else begin
            stage.valid <= pop;
            stage.prod  <= prod_ext;
        end
    end

    assign acc_sum = acc + OUT_W'(stage.prod);

    // The last product of a group loads the result and clears the
    // accumulator in the same edge, so groups run back to back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            mac_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (stage.valid) begin
                if (cnt == LAST) begin
                    mac_out   <= acc_sum;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if ((in_valid_a && !in_ready_a) || (in_valid_b && !in_ready_b)) begin
            overflow <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mac_stream.sv
// ============================================================================
// Module : tb_mac_stream
// Brief  : Directed self-checking bench for mac_stream at default parameters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mac_stream;

    localparam int DATA_W = 4;
    localparam int OUT_W  = 11;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] in_a;
    logic              in_valid_a;
    logic              in_ready_a;
    logic [DATA_W-1:0] in_b;
    logic              in_valid_b;
    logic              in_ready_b;
    logic [OUT_W-1:0]  mac_out;
    logic              out_valid;
    logic              overflow;

    int checks;
    int failures;
    int cyc;
    int npulse;
    int p1_cyc;
    int p_last_cyc;
    int p1_mac;
    int p_last_mac;
    int t_last;
    int qa[$];
    int qb[$];

    mac_stream #(.DATA_W(4), .ACC_LEN(8), .BUF_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_a       (in_a),
        .in_valid_a (in_valid_a),
        .in_ready_a (in_ready_a),
        .in_b       (in_b),
        .in_valid_b (in_valid_b),
        .in_ready_b (in_ready_b),
        .mac_out    (mac_out),
        .out_valid  (out_valid),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later, logging result pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid) begin
            npulse++;
            if (npulse == 1) begin
                p1_cyc = cyc;
                p1_mac = int'(mac_out);
            end
            p_last_cyc = cyc;
            p_last_mac = int'(mac_out);
        end
    endtask

    task automatic clear_log();
        npulse     = 0;
        p1_cyc     = -1;
        p_last_cyc = -1;
        p1_mac     = -1;
        p_last_mac = -1;
    endtask

    // Push queued operands on each channel whenever that channel is ready.
    task automatic feed_all(input int budget);
        for (int i = 0; i < budget && (qa.size() > 0 || qb.size() > 0); i++) begin
            logic ga;
            logic gb;
            ga = (qa.size() > 0) && in_ready_a;
            gb = (qb.size() > 0) && in_ready_b;
            in_valid_a = ga;
            in_valid_b = gb;
            if (ga) in_a = DATA_W'(qa[0]);
            if (gb) in_b = DATA_W'(qb[0]);
            tick();
            if (ga) void'(qa.pop_front());
            if (gb) void'(qb.pop_front());
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        reset      = 1'b1;
        in_a       = '0;
        in_b       = '0;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        clear_log();

        // Reset values
        idle(2);
        chk("rst_mac_out", 32'(mac_out), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_ready_a", 32'(in_ready_a), 32'd1);
        chk("rst_ready_b", 32'(in_ready_b), 32'd1);
        reset = 1'b0;
        idle(3);
        chk("rst_no_pulse", 32'(npulse), 32'd0);

        // Full-scale group: 8 x 15*15 = 1800
        clear_log();
        for (int i = 0; i < 8; i++) begin
            qa.push_back(15);
            qb.push_back(15);
        end
        feed_all(20);
        t_last = cyc;
        idle(10);
        chk("full_pulses", 32'(npulse), 32'd1);
        chk("full_mac_out", 32'(p1_mac), 32'h708);
        chk("full_latency", 32'(p1_cyc), 32'(t_last + 2));

        // Skew and backpressure: A fills its buffer while B is idle
        clear_log();
        for (int i = 1; i <= 8; i++) qa.push_back(i);
        feed_all(6);
        chk("skew_a_pushed", 32'(qa.size()), 32'd4);
        chk("skew_ready_a_low", 32'(in_ready_a), 32'd0);
        for (int i = 0; i < 8; i++) qb.push_back(1);
        feed_all(40);
        chk("skew_drained", 32'(qa.size() + qb.size()), 32'd0);
        idle(6);
        chk("skew_pulses", 32'(npulse), 32'd1);
        chk("skew_mac_out", 32'(p1_mac), 32'd36);
        chk("skew_overflow", 32'(overflow), 32'd0);

        // Overflow: ignore ready on A for 6 cycles
        clear_log();
        in_a       = DATA_W'(2);
        in_valid_a = 1'b1;
        idle(6);
        in_valid_a = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) qa.push_back(2);
        for (int i = 0; i < 8; i++) qb.push_back(3);
        feed_all(40);
        chk("ovf_drained", 32'(qa.size() + qb.size()), 32'd0);
        idle(6);
        chk("ovf_pulses", 32'(npulse), 32'd1);
        chk("ovf_mac_out", 32'(p1_mac), 32'd48);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Back-to-back groups
        clear_log();
        for (int i = 0; i < 16; i++) begin
            qa.push_back(2);
            qb.push_back(3);
        end
        feed_all(40);
        idle(6);
        chk("b2b_pulses", 32'(npulse), 32'd2);
        chk("b2b_mac_first", 32'(p1_mac), 32'd48);
        chk("b2b_mac_second", 32'(p_last_mac), 32'd48);
        chk("b2b_spacing", 32'(p_last_cyc - p1_cyc), 32'd8);

        // Mid-group reset discards the partial sum
        clear_log();
        for (int i = 0; i < 5; i++) begin
            qa.push_back(1);
            qb.push_back(1);
        end
        feed_all(20);
        idle(3);
        chk("mid_no_pulse", 32'(npulse), 32'd0);
        reset = 1'b1;
        idle(2);
        chk("mid_rst_mac_out", 32'(mac_out), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        idle(1);
        for (int i = 0; i < 8; i++) begin
            qa.push_back(1);
            qb.push_back(1);
        end
        feed_all(20);
        idle(6);
        chk("mid_pulses", 32'(npulse), 32'd1);
        chk("mid_mac_out", 32'(p1_mac), 32'd8);

`ifdef MAC_SIGNED_EN
        // Signed: 8 x (-8 * 7) = -448
        clear_log();
        for (int i = 0; i < 8; i++) begin
            qa.push_back(8);
            qb.push_back(7);
        end
        feed_all(20);
        idle(6);
        chk("signed_pulses", 32'(npulse), 32'd1);
        chk("signed_mac_out", 32'(p1_mac), 32'h640);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
